cond_unit: RTL and testbench

Conditional-execution and status-flag unit for the execute→commit boundary of the processor pipeline. It consumes the `{N,Z,C,V}` flags produced by the ALU, holds the architectural flag register, and evaluates each instruction's 4-bit condition field. It gates register, memory and PC writes into the commit stage and returns the carry flag to the ALU for `ADC`/`SBC`/`RSC`. It also resolves the one-cycle flag hazard created by committing flags one stage after execute.

---
 rtl/cond_unit_pkg.sv | 46 ++++
 rtl/cond_unit_if.sv | 34 +++
 rtl/cond_check.sv | 35 +++
 rtl/cond_unit.sv | 101 ++++++++++
 tb/tb_cond_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cond_unit_pkg.sv
// cond_unit shared types: condition codes, flag indices, commit bundle.
package cond_unit_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       pc_src;
        logic [3:0] flags;
        logic [1:0] mask;
    } commit_t;

    function automatic logic cond_always(input logic [3:0] cond);
        return (cond == COND_AL) || (cond == COND_NV);
    endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Execute-side request and commit-side control bundle for cond_unit.
interface cond_unit_if;

    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       CFlag;
    logic [3:0] Flags;
    logic       CommitValid;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;

    modport master (
        output Valid, Cond, ALUFlags, FlagW,
        output PCS, RegW, MemW, NoWrite,
        input  Stall, CFlag, Flags,
        input  CommitValid, PCSrc, RegWrite, MemWrite
    );

    modport slave (
        input  Valid, Cond, ALUFlags, FlagW,
        input  PCS, RegW, MemW, NoWrite,
        output Stall, CFlag, Flags,
        output CommitValid, PCSrc, RegWrite, MemWrite
    );

endinterface

// File: rtl/cond_check.sv
// ARM condition-field evaluator against a {N,Z,C,V} flag set.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    output logic       CondTrue
);

    always_comb begin
        CondTrue = 1'b1;
        unique case (cond_e'(Cond))
            COND_EQ: CondTrue = Z;
            COND_NE: CondTrue = !Z;
            COND_CS: CondTrue = C;
            COND_CC: CondTrue = !C;
            COND_MI: CondTrue = N;
            COND_PL: CondTrue = !N;
            COND_VS: CondTrue = V;
            COND_VC: CondTrue = !V;
            COND_HI: CondTrue = C && !Z;
            COND_LS: CondTrue = !C || Z;
            COND_GE: CondTrue = (N == V);
            COND_LT: CondTrue = (N != V);
            COND_GT: CondTrue = !Z && (N == V);
            COND_LE: CondTrue = Z || (N != V);
            COND_AL: CondTrue = 1'b1;
            COND_NV: CondTrue = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Flag register, condition gating and commit register at execute->commit.
// COND_FLAG_BYPASS_EN: overlay pending flags instead of stalling.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic        CLK,
    input  logic        Reset,
    cond_unit_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] eff;
    commit_t    commit_q;
    commit_t    commit_d;
    state_e     state_q;
    state_e     state_d;
    logic       hazard;
    logic       stall;
    logic       accept;
    logic       cond_true;
    logic       cond_ex;

`ifdef COND_FLAG_BYPASS_EN
    // Pending N,Z and C,V pairs win over the architectural copy.
    assign eff[FLAG_N:FLAG_Z] = commit_q.mask[1] ?
                                commit_q.flags[FLAG_N:FLAG_Z] :
                                flags_q[FLAG_N:FLAG_Z];
    assign eff[FLAG_C:FLAG_V] = commit_q.mask[0] ?
                                commit_q.flags[FLAG_C:FLAG_V] :
                                flags_q[FLAG_C:FLAG_V];
    assign hazard = 1'b0;
`else
    assign eff = flags_q;
    // Any pending C write is treated as a carry read by the new op.
    assign hazard = bus.Valid
                 && (commit_q.mask != 2'b00)
                 && (!cond_always(bus.Cond) || commit_q.mask[0]);
`endif

    cond_check u_check (
        .Cond     (bus.Cond),
        .N        (eff[FLAG_N]),
        .Z        (eff[FLAG_Z]),
        .C        (eff[FLAG_C]),
        .V        (eff[FLAG_V]),
        .CondTrue (cond_true)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                stall = hazard && !Reset;
                if (hazard) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign accept  = bus.Valid && !stall;
    assign cond_ex = accept && cond_true;

    always_comb begin
        commit_d           = '0;
        commit_d.valid     = accept;
        commit_d.reg_write = cond_ex && bus.RegW && !bus.NoWrite;
        commit_d.mem_write = cond_ex && bus.MemW;
        commit_d.pc_src    = cond_ex && bus.PCS;
        commit_d.mask      = bus.FlagW & {2{cond_ex}};
        if (accept) commit_d.flags = bus.ALUFlags;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q  <= FLAG_RESET;
            commit_q <= '0;
            state_q  <= ST_RUN;
        end else begin
            if (commit_q.mask[1])
                flags_q[FLAG_N:FLAG_Z] <= commit_q.flags[FLAG_N:FLAG_Z];
            if (commit_q.mask[0])
                flags_q[FLAG_C:FLAG_V] <= commit_q.flags[FLAG_C:FLAG_V];
            commit_q <= commit_d;
            state_q  <= state_d;
        end
    end

    assign bus.Stall       = stall;
    assign bus.CFlag       = eff[FLAG_C];
    assign bus.Flags       = flags_q;
    assign bus.CommitValid = commit_q.valid;
    assign bus.RegWrite    = commit_q.reg_write;
    assign bus.MemWrite    = commit_q.mem_write;
    assign bus.PCSrc       = commit_q.pc_src;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: vector table plus hazard/reset sequences.
module tb_cond_unit;
    import cond_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cond_unit_if bus();

    cond_unit #(.FLAG_RESET(4'b0000)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowr;
        logic       stall;
        logic [3:0] exp;
        logic       fchk;
        logic [3:0] fexp;
    } vec_t;

    logic [3:0] sbq[$];
    vec_t       tbl[$];
    int         n_chk = 0;
    int         n_pass = 0;

    localparam logic [3:0] AL = 4'hE;
    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] NE = 4'h1;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic v, input logic [3:0] c, input logic [3:0] a,
        input logic [1:0] fw, input logic pcs, input logic rw,
        input logic mw, input logic nw, input logic st,
        input logic [3:0] e, input logic fc, input logic [3:0] fe);
        vec_t r;
        r.valid = v; r.cond = c; r.alu = a; r.flagw = fw;
        r.pcs = pcs; r.regw = rw; r.memw = mw; r.nowr = nw;
        r.stall = st; r.exp = e; r.fchk = fc; r.fexp = fe;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 4'h0);
    endfunction

    // Signed conditions straight from the ARM table.
    function automatic logic ref_cond(input logic [3:0] c,
                                      input logic [3:0] f);
        logic n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // exp/commit order: {CommitValid, RegWrite, MemWrite, PCSrc}
    task automatic step(input vec_t v, input string name);
        logic [3:0] e;
        bus.Valid    = v.valid;
        bus.Cond     = v.cond;
        bus.ALUFlags = v.alu;
        bus.FlagW    = v.flagw;
        bus.PCS      = v.pcs;
        bus.RegW     = v.regw;
        bus.MemW     = v.memw;
        bus.NoWrite  = v.nowr;
        sbq.push_back(v.exp);
        @(negedge clk);
        chk({name, " stall"}, {3'b000, bus.Stall}, {3'b000, v.stall});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({name, " commit"},
            {bus.CommitValid, bus.RegWrite, bus.MemWrite, bus.PCSrc}, e);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk({name, " flags"}, bus.Flags, exp);
    endtask

    initial begin
        for (int f = 0; f < 16; f++) begin
            tbl.push_back(mk(1, AL, 4'(f), 2'b11, 0, 1, 0, 1, 0,
                             4'b1000, 0, 4'h0));
            tbl.push_back(mk(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0,
                             4'b0000, 1, 4'(f)));
            for (int c = 10; c < 14; c++)
                tbl.push_back(mk(1, 4'(c), 4'h0, 2'b00, 0, 1, 0, 0, 0,
                                 {1'b1, ref_cond(4'(c), 4'(f)), 2'b00},
                                 0, 4'h0));
        end

        bus.Valid = 0; bus.Cond = 0; bus.ALUFlags = 0; bus.FlagW = 0;
        bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.NoWrite = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 4'b0000);
        chk("reset commit",
            {bus.CommitValid, bus.RegWrite, bus.MemWrite, bus.PCSrc},
            4'b0000);
        chk("reset stall", {3'b000, bus.Stall}, 4'b0000);
        rst = 1'b0;

        step(mk(1, AL, 4'b0100, 2'b11, 0, 1, 0, 1, 0, 4'b1000, 0, 0), "cmp");
`ifdef COND_FLAG_BYPASS_EN
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1100, 0, 0), "eq_byp");
        step(idle(), "idle_a");
`else
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 1, 4'b0000, 0, 0), "eq_stall");
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1100, 0, 0), "eq_hold");
`endif
        chk_flags("cmp", 4'b0100);

        step(mk(1, AL, 4'b1111, 2'b11, 0, 0, 0, 1, 0, 4'b1000, 0, 0), "set1111");
        step(idle(), "idle_b");
        chk_flags("set1111", 4'b1111);
        step(mk(1, AL, 4'b0000, 2'b10, 0, 0, 0, 1, 0, 4'b1000, 0, 0), "partial");
        chk_flags("partial_early", 4'b1111);
        step(idle(), "idle_c");
        chk_flags("partial", 4'b0011);

        step(mk(1, EQ, 4'b0100, 2'b11, 1, 1, 1, 0, 0, 4'b1000, 0, 0), "eq_fail");
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1000, 0, 0), "eq_after");
        chk_flags("eq_fail", 4'b0011);
        step(mk(1, NE, 4'h0, 2'b00, 1, 1, 1, 1, 0, 4'b1011, 0, 0), "ne_nowr");
        chk_flags("ne_nowr", 4'b0011);

        step(mk(1, AL, 4'b0100, 2'b11, 0, 0, 0, 1, 0, 4'b1000, 0, 0), "cmp2");
        rst = 1'b1;
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b0000, 0, 0), "rst_pend");
        rst = 1'b0;
        chk_flags("rst_pend", 4'b0000);
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1000, 0, 0), "eq_post1");

        step(mk(1, AL, 4'b0100, 2'b11, 0, 0, 0, 1, 0, 4'b1000, 0, 0), "cmp3");
`ifdef COND_FLAG_BYPASS_EN
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1100, 0, 0), "eq_s3");
`else
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 1, 4'b0000, 0, 0), "eq_s3");
`endif
        rst = 1'b1;
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b0000, 0, 0), "rst_hold");
        rst = 1'b0;
        chk_flags("rst_hold", 4'b0000);
        step(mk(1, EQ, 4'h0, 2'b00, 0, 1, 0, 0, 0, 4'b1000, 0, 0), "eq_post2");

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("sig%0d", i));
            if (tbl[i].fchk) begin
                chk_flags($sformatf("sig%0d", i), tbl[i].fexp);
                chk($sformatf("sig%0d cflag", i), {3'b000, bus.CFlag},
                    {3'b000, tbl[i].fexp[1]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
